// File: rtl/hpi_pkg.sv
// Shared types for the HPI responder.
//   hpi_reg_e   : host register select carried on OTG_ADDR
//   hpi_state_e : access-sequencing FSM states
//   hpi_acc_t   : per-cycle decoded host access
//   STAT_*      : bit positions inside the STATUS word
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA   = 2'd0,
    HPI_MBX    = 2'd1,
    HPI_ADDR   = 2'd2,
    HPI_STATUS = 2'd3
  } hpi_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_FETCH = 2'd1,
    ST_RD_HOLD  = 2'd2,
    ST_WR_HOLD  = 2'd3
  } hpi_state_e;

  typedef struct packed {
    logic     rd;
    logic     wr;
    hpi_reg_e sel;
  } hpi_acc_t;

  localparam int STAT_MBX_OUT_FULL = 0;
  localparam int STAT_MBX_IN_FULL  = 1;
  localparam int STAT_OVERRUN      = 2;

  function automatic logic [15:0] status_word(input logic ovr,
                                              input logic in_full,
                                              input logic out_full);
    logic [15:0] w;
    w                    = '0;
    w[STAT_OVERRUN]      = ovr;
    w[STAT_MBX_IN_FULL]  = in_full;
    w[STAT_MBX_OUT_FULL] = out_full;
    return w;
  endfunction

endpackage

// File: rtl/hpi_resp_ram.sv
// Single-port 2^AW x 16 synchronous RAM. One access per cycle when en is
// high: a write if we, else a read whose data appears on rdata after the edge.
//   Clk   : clock
//   en    : access enable
//   we    : write (1) / read (0)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module hpi_resp_ram #(
  parameter int AW = 10
) (
  input  logic          Clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge Clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/hpi_responder.sv
// Chip-side responder for a CY7C67200-style Host Port Interface. Serves host
// accesses to DATA (auto-incrementing word RAM), MAILBOX, ADDRESS and STATUS,
// and exposes a two-way mailbox to local device logic.
//   Clk, Reset        : clock, synchronous active-high reset
//   OTG_DATA          : bidirectional host bus, driven only while a read holds
//   OTG_ADDR          : register select
//   OTG_CS_N/RD_N/WR_N: active-low strobes, synchronous to Clk
//   OTG_RST_N         : host soft reset (RAM contents preserved)
//   OTG_INT           : high while the outgoing mailbox is full
//   mbx_rx_*          : host->device mailbox (data, full flag, consume ack)
//   mbx_tx_*          : device->host mailbox (data, valid, ready)
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ack,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_valid,
  output logic        mbx_tx_ready
);

  hpi_state_e  state;
  hpi_reg_e    rd_sel;
  hpi_acc_t    acc;
  logic [15:0] addr, rd_q, mbx_in, mbx_out, ram_rdata, din;
  logic        in_full, out_full, overrun;
  logic        srst, tx_fire, idle, ram_en;

  // Both strobes low is a protocol error and decodes as neither access.
  assign acc.rd = ~OTG_CS_N & ~OTG_RD_N &  OTG_WR_N;
  assign acc.wr = ~OTG_CS_N & ~OTG_WR_N &  OTG_RD_N;
  assign acc.sel = hpi_reg_e'(OTG_ADDR);

  assign srst    = Reset | ~OTG_RST_N;
  assign idle    = (state == ST_IDLE);
  assign tx_fire = mbx_tx_valid & ~out_full;
  assign din     = OTG_DATA;

  // The RAM is touched only on the first cycle of a DATA access, so a held
  // strobe never causes a second write or a second read.
  assign ram_en = idle & (acc.rd | acc.wr) & (acc.sel == HPI_DATA);

  hpi_resp_ram #(.AW(AW)) u_ram (
    .Clk   (Clk),
    .en    (ram_en),
    .we    (acc.wr),
    .addr  (addr[AW:1]),
    .wdata (din),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (srst) begin
      state    <= ST_IDLE;
      rd_sel   <= HPI_DATA;
      addr     <= '0;
      rd_q     <= '0;
      mbx_in   <= '0;
      mbx_out  <= '0;
      in_full  <= 1'b0;
      out_full <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tx_fire) begin
        mbx_out  <= mbx_tx_data;
        out_full <= 1'b1;
      end
      // A host mailbox write later in this block overrides the ack.
      if (mbx_rx_ack) in_full <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (acc.wr) begin
            state <= ST_WR_HOLD;
            case (acc.sel)
              HPI_DATA: addr <= addr + 16'd2;
              HPI_MBX: begin
                mbx_in  <= din;
                in_full <= 1'b1;
                if (in_full & ~mbx_rx_ack) overrun <= 1'b1;
              end
              HPI_ADDR: addr <= din;
              default: ;
            endcase
          end else if (acc.rd) begin
            state  <= ST_RD_FETCH;
            rd_sel <= acc.sel;
            // Only clear a full mailbox; tx_fire cannot coincide with that,
            // so a word loaded this cycle is never dropped.
            if (acc.sel == HPI_MBX && out_full) out_full <= 1'b0;
          end
        end
        ST_RD_FETCH: begin
          state <= ST_RD_HOLD;
          case (rd_sel)
            HPI_DATA: begin
              rd_q <= ram_rdata;
              addr <= addr + 16'd2;
            end
            HPI_MBX:  rd_q <= mbx_out;
            HPI_ADDR: rd_q <= addr;
            default: begin
              rd_q    <= status_word(overrun, in_full, out_full);
              overrun <= 1'b0;
            end
          endcase
        end
        ST_RD_HOLD: if (!acc.rd) state <= ST_IDLE;
        ST_WR_HOLD: if (!acc.wr) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign OTG_DATA     = (state == ST_RD_HOLD && acc.rd) ? rd_q : 16'hzzzz;
  assign OTG_INT      = out_full;
  assign mbx_tx_ready = ~out_full;
  assign mbx_rx_valid = in_full;
  assign mbx_rx_data  = mbx_in;

endmodule

// File: tb/tb_hpi_responder.sv
module tb_hpi_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  wire  [15:0] otg_data;
  logic [15:0] host_dq = '0;
  logic        host_oe = 1'b0;
  logic [1:0]  otg_addr = '0;
  logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rst_n = 1'b1;
  logic        otg_int, rx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_ack = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;

  always #5 Clk = ~Clk;
  assign otg_data = host_oe ? host_dq : 16'hzzzz;

  hpi_responder #(.AW(AW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_DATA     (otg_data),
    .OTG_ADDR     (otg_addr),
    .OTG_CS_N     (cs_n),
    .OTG_RD_N     (rd_n),
    .OTG_WR_N     (wr_n),
    .OTG_RST_N    (rst_n),
    .OTG_INT      (otg_int),
    .mbx_rx_data  (rx_data),
    .mbx_rx_valid (rx_valid),
    .mbx_rx_ack   (rx_ack),
    .mbx_tx_data  (tx_data),
    .mbx_tx_valid (tx_valid),
    .mbx_tx_ready (tx_ready)
  );

  // Behavioural model of the host-visible state.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_addr, m_mbx_in, m_mbx_out;
  logic        m_in_full, m_out_full, m_ovr;

  logic [15:0] exp_q [$];
  string       name_q [$];
  int          checks = 0, errors = 0;
  event        rd_sample;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_mbx_in = '0; m_mbx_out = '0;
    m_in_full = 1'b0; m_out_full = 1'b0; m_ovr = 1'b0;
  endtask

  // Monitor: each host read sample is matched against the oldest expectation.
  initial begin
    forever begin
      @(rd_sample);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: got %h with no expected value", otg_data);
      end else begin
        logic [15:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, otg_data, e);
      end
    end
  end

  task automatic host_write(input logic [1:0] r, input logic [15:0] d, input int hold);
    @(negedge Clk);
    otg_addr = r; host_dq = d; host_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (hold) @(negedge Clk);
    cs_n = 1'b1; wr_n = 1'b1; host_oe = 1'b0;
    case (r)
      2'd0: begin m_mem[m_addr[AW:1]] = d; m_addr = m_addr + 16'd2; end
      2'd1: begin if (m_in_full) m_ovr = 1'b1; m_mbx_in = d; m_in_full = 1'b1; end
      2'd2: m_addr = d;
      default: ;
    endcase
    @(negedge Clk);
  endtask

  task automatic host_read(input logic [1:0] r, input string nm, input int extra);
    logic [15:0] e;
    case (r)
      2'd0: begin e = m_mem[m_addr[AW:1]]; m_addr = m_addr + 16'd2; end
      2'd1: begin e = m_mbx_out; m_out_full = 1'b0; end
      2'd2: e = m_addr;
      default: begin e = {13'd0, m_ovr, m_in_full, m_out_full}; m_ovr = 1'b0; end
    endcase
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge Clk);
    otg_addr = r; cs_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 -> rd_sample;
    repeat (extra) @(posedge Clk);
    @(negedge Clk);
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic dev_offer(input logic [15:0] d);
    logic was_ready;
    @(negedge Clk);
    chk("tx_ready", {15'd0, tx_ready}, {15'd0, ~m_out_full});
    was_ready = ~m_out_full;
    tx_valid = 1'b1; tx_data = d;
    @(negedge Clk);
    tx_valid = 1'b0;
    if (was_ready) begin m_out_full = 1'b1; m_mbx_out = d; end
    chk("otg_int_after_offer", {15'd0, otg_int}, {15'd0, m_out_full});
  endtask

  task automatic dev_ack();
    @(negedge Clk);
    rx_ack = 1'b1;
    @(negedge Clk);
    rx_ack = 1'b0;
    m_in_full = 1'b0;
    chk("rx_valid_after_ack", {15'd0, rx_valid}, 16'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    chk("reset_tx_ready", {15'd0, tx_ready}, 16'd1);
    chk("reset_otg_int", {15'd0, otg_int}, 16'd0);
    chk("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
    chk("reset_rx_data", rx_data, 16'h0000);
    Reset = 1'b0;
    host_read(2'd2, "reset_addr", 0);

    // Fill the whole RAM so every later read has a known value.
    host_write(2'd2, 16'h0000, 1);
    for (int i = 0; i < DEPTH; i++) host_write(2'd0, 16'($urandom), 1);

    // Auto-increment write/read.
    host_write(2'd2, 16'h0100, 1);
    host_write(2'd0, 16'hAAAA, 1);
    host_write(2'd0, 16'h5555, 2);
    host_write(2'd2, 16'h0100, 1);
    host_read(2'd0, "data_aaaa", 0);
    host_read(2'd0, "data_5555", 1);
    host_read(2'd2, "addr_0104", 0);

    // Long write strobe acts once.
    host_write(2'd2, 16'h0200, 1);
    host_write(2'd0, 16'h1234, 6);
    host_read(2'd2, "hold_addr", 0);
    host_write(2'd2, 16'h0200, 1);
    host_read(2'd0, "hold_data", 0);
    host_read(2'd0, "hold_next_word", 0);

    // Device-to-host mailbox.
    dev_offer(16'hBEEF);
    dev_offer(16'hDEAD);   // not accepted: mailbox already full
    host_read(2'd3, "status_out_full", 0);
    host_read(2'd1, "mbx_beef", 0);
    chk("otg_int_after_read", {15'd0, otg_int}, 16'd0);

    // Host-to-device mailbox overrun.
    host_write(2'd1, 16'h0011, 1);
    host_write(2'd1, 16'h0022, 2);
    chk("rx_data_0022", rx_data, m_mbx_in);
    chk("rx_valid_set", {15'd0, rx_valid}, 16'd1);
    host_read(2'd3, "status_ovr", 0);
    host_read(2'd3, "status_ovr_cleared", 0);
    dev_ack();
    host_read(2'd3, "status_empty", 0);

    // Address wrap and RAM aliasing.
    host_write(2'd2, 16'hFFFE, 1);
    host_write(2'd0, 16'h7777, 1);
    host_read(2'd2, "addr_wrap", 0);
    host_write(2'd2, 16'h07FE, 1);
    host_read(2'd0, "ram_3ff", 0);

    // Reset during a held read; the still-held strobe starts a fresh read.
    dev_offer(16'h4242);
    host_write(2'd2, 16'h0010, 1);
    @(negedge Clk);
    otg_addr = 2'd0; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_otg_int", {15'd0, otg_int}, 16'd0);
    chk("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    model_reset();
    Reset = 1'b0;
    exp_q.push_back(m_mem[0]); name_q.push_back("fresh_read_ram0");
    m_addr = 16'd2;
    repeat (3) @(posedge Clk);
    #1 -> rd_sample;
    @(negedge Clk);
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge Clk);
    host_read(2'd2, "addr_after_rst", 0);

    // Host soft reset keeps RAM.
    host_write(2'd1, 16'h9999, 1);
    host_write(2'd2, 16'h0040, 1);
    @(negedge Clk);
    rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    rst_n = 1'b1;
    model_reset();
    chk("softrst_rx_valid", {15'd0, rx_valid}, 16'd0);
    host_read(2'd2, "softrst_addr", 0);
    host_read(2'd0, "softrst_ram0", 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0: host_write(2'd2, ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom), $urandom_range(1, 3));
        1, 2: host_write(2'd0, 16'($urandom), $urandom_range(1, 4));
        3: host_read(2'd0, "rnd_data", $urandom_range(0, 2));
        4: host_read(2'd2, "rnd_addr", $urandom_range(0, 2));
        5: host_read(2'd3, "rnd_status", $urandom_range(0, 2));
        6: host_write(2'd1, 16'($urandom), $urandom_range(1, 3));
        7: dev_ack();
        8: dev_offer(16'($urandom));
        default: host_read(2'd1, "rnd_mbx", $urandom_range(0, 2));
      endcase
      if (op == 6) chk("rnd_rx_data", rx_data, m_mbx_in);
    end

    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
